fp_addsub_issue: RTL and testbench
==================================

// Module: fp_addsub_issue
// PURPOSE
//  Pipelined issue/retire shell around the combinational FPAdder for FADD/FSUB.
//  Accepts requests from FPU decode over valid/ready and registers the operands (S1).
//  Applies the FSUB sign flip, drives FPAdder, and registers the sum plus its tag (S2).
//  The S2 register is the output toward FPU writeback.
// PARAMETERS
//  BUS_WIDTH   64  operand/result width; 64 = double, 32 = single (passed to FPAdder)
//  TAG_WIDTH   5   destination-register tag carried alongside each op
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst        in   1          synchronous, active-high reset
//  flush      in   1          sync; kills all in-flight ops
//  in_valid   in   1          request valid
//  in_ready   out  1          request accepted when in_valid & in_ready
//  in_sub     in   1          0 = A+B, 1 = A-B
//  in_a       in   BUS_WIDTH  operand A (IEEE-754)
//  in_b       in   BUS_WIDTH  operand B (IEEE-754)
//  in_tag     in   TAG_WIDTH  destination tag
//  out_valid  out  1          result valid
//  out_ready  in   1          consumer ready; transfer when out_valid & out_ready
//  out_result out  BUS_WIDTH  FPAdder sum
//  out_tag    out  TAG_WIDTH  tag of out_result
//  out_flags  out  2          {invalid, overflow}
// BEHAVIOUR
//  - Reset: s1_valid = s2_valid = 0, out_valid = 0; out_result, out_tag, out_flags = 0. in_ready = 1 the cycle after rst deasserts.
//  - Two stages, latency 2: accepted at edge N -> S1 at N+1 -> out_valid high from edge N+2 when unstalled.
//  - s2_adv = ~s2_valid | out_ready; s1_adv = s2_adv.
//  - in_ready = ~flush & (~s1_valid | s1_adv); combinational, no in_valid dependence.
//  - S1 captures {a, b ^ (in_sub << BUS_WIDTH-1), tag} on accept. FSUB flips B's sign bit only, NaN payload untouched.
//  - S2 captures the FPAdder output of S1, plus tag and flags, when s1_valid & s2_adv.
//  - Full throughput: 1 op/cycle with out_ready held high.
//  - Backpressure: out_ready low freezes S2 and S1 with contents stable. in_ready falls once S1 is full.
//  - Stalled outputs: out_result, out_tag, out_flags stay constant while out_valid & ~out_ready.
//  - Simultaneous events:
//    - Consume of S2 and advance of S1 in the same cycle: S2 reloads with no bubble.
//    - Accept into S1 while S1 advances: S1 reloads with no bubble.
//  - flush: the next edge clears s1_valid and s2_valid; nothing is accepted that cycle. A concurrent out handshake still counts as delivered.
//  - rst dominates flush and every handshake. Reset mid-operation discards all ops; no partial output appears.
//  - Data registers are not cleared by flush. Only the valids are.
// CONFIGURATION
//  FP_ADD_EXC_FLAGS_EN defined: out_flags computed from S1 operands and adder output.
//    - invalid = result is NaN, i.e. inf + -inf, or either input has exp all-ones with mantissa != 0.
//    - overflow = result is +/-inf and neither input is inf.
//  Not defined: out_flags tied to 2'b00, no flag logic. Port list is identical in both builds.
// STRUCTURE
//  Shared package fpu_pkg:
//    - BUS_WIDTH-dependent MANTISSA_SIZE, EXPONENT_SIZE, BIAS
//    - NAN, INFINITY_P, INFINITY_N constants
//    - FLAG_INVALID=1 and FLAG_OVERFLOW=0 bit indices
//  One sub-module instance: FPAdder #(.BUS_WIDTH(BUS_WIDTH)) between S1 and S2. No other submodules.
//  Classification helpers (is_nan, is_inf) live as functions in fpu_pkg.
// TESTING (BUS_WIDTH=64)
//  1. Latency and add: in_a=3FF0000000000000 (1.0), in_b=4000000000000000 (2.0), sub=0, tag=3, out_ready=1
//     -> out_valid two edges after accept; out_result=4008000000000000; out_tag=3.
//  2. FSUB: 1.0 - 1.0 (sub=1) -> out_result=0000000000000000, out_flags=00.
//  3. Special case: +inf (7FF0000000000000) + -inf (FFF0000000000000)
//     -> out_result=7FF8000000000000, out_flags=10 with FP_ADD_EXC_FLAGS_EN, 00 without.
//  4. Backpressure: stream 4 ops tags 0..3, hold out_ready=0 for 5 cycles
//     -> in_ready low after 2 accepts; out_result/tag stable; after release, tags 0,1,2,3 in order, none lost or duplicated.
//  5. Throughput: 16 back-to-back ops with out_ready=1 -> 16 results on 16 consecutive cycles.
//  6. flush/reset: flush with 2 ops in flight -> out_valid=0 next cycle and both ops never appear.
//     rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 field sizes, special-value constants, flag indices
// and classification helpers for both single (32) and double (64) precision buses.
package fpu_pkg;

  localparam int FPU_BUS_WIDTH = 64;
  localparam int MANTISSA_SIZE = (FPU_BUS_WIDTH == 32) ? 23 : 52;
  localparam int EXPONENT_SIZE = (FPU_BUS_WIDTH == 32) ? 8 : 11;
  localparam int BIAS          = (1 << (EXPONENT_SIZE - 1)) - 1;

  localparam logic [63:0] NAN        = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] INFINITY_P = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] INFINITY_N = 64'hFFF0_0000_0000_0000;

  localparam int FLAG_INVALID  = 1;
  localparam int FLAG_OVERFLOW = 0;

  function automatic int mantissa_size(input int bw);
    return (bw == 32) ? 23 : 52;
  endfunction

  function automatic int exponent_size(input int bw);
    return (bw == 32) ? 8 : 11;
  endfunction

  // Values narrower than 64 bits live in the low bits of the returned word.
  function automatic logic [63:0] nan_of(input int bw);
    return (bw == 32) ? 64'h0000_0000_7FC0_0000 : NAN;
  endfunction

  function automatic logic [63:0] inf_of(input int bw, input logic sign);
    if (bw == 32) return {32'h0, sign, 8'hFF, 23'h0};
    return sign ? INFINITY_N : INFINITY_P;
  endfunction

  function automatic logic is_nan(input logic [63:0] x, input int bw);
    if (bw == 32) return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'h0);
  endfunction

  function automatic logic is_inf(input logic [63:0] x, input int bw);
    if (bw == 32) return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    return (x[62:52] == 11'h7FF) && (x[51:0] == 52'h0);
  endfunction

endpackage

// File: rtl/fp_addsub_issue_fpadder.sv
// FPAdder: combinational IEEE-754 adder (round-to-nearest-even, subnormals supported).
// Subtraction is expected to arrive as a sign-flipped B operand.
module FPAdder
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64
) (
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  output logic [BUS_WIDTH-1:0] result
);

  localparam int M  = mantissa_size(BUS_WIDTH);
  localparam int E  = exponent_size(BUS_WIDTH);
  localparam int SW = M + 4;
  localparam int XW = E + 2;
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << E) - 1);

  logic         sa, sb;
  logic [E-1:0] ea, eb;
  logic [M-1:0] ma, mb;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;

  logic         eff_sub, sign_big;
  logic [E-1:0] e_big, e_small, e_diff;
  logic [M:0]   sig_big, sig_small;

  // Order operands by magnitude so the subtraction below never goes negative.
  always_comb begin
    eff_sub = sa ^ sb;
    if ({ea, ma} >= {eb, mb}) begin
      sign_big  = sa;
      e_big     = (ea == '0) ? E'(1) : ea;
      sig_big   = {ea != '0, ma};
      e_small   = (eb == '0) ? E'(1) : eb;
      sig_small = {eb != '0, mb};
    end else begin
      sign_big  = sb;
      e_big     = (eb == '0) ? E'(1) : eb;
      sig_big   = {eb != '0, mb};
      e_small   = (ea == '0) ? E'(1) : ea;
      sig_small = {ea != '0, ma};
    end
    e_diff = e_big - e_small;
  end

  logic [SW-1:0] small_ext, small_mask, aligned;
  logic          sticky;
  logic [SW:0]   big_ext, mag;

  // Three extra low bits (guard, round, sticky); everything shifted past them folds into sticky.
  always_comb begin
    small_ext  = {sig_small, 3'b000};
    small_mask = ~({SW{1'b1}} << e_diff);
    sticky     = |(small_ext & small_mask);
    aligned    = (small_ext >> e_diff) | {{(SW-1){1'b0}}, sticky};
    big_ext    = {1'b0, sig_big, 3'b000};
    mag        = eff_sub ? (big_ext - {1'b0, aligned}) : (big_ext + {1'b0, aligned});
  end

  logic [XW-1:0] lz, shamt, exp_n, exp_f;
  logic [SW-1:0] norm;
  logic          round_up;
  logic [M+1:0]  rounded;
  logic [M-1:0]  mant_f;

  always_comb begin
    lz = XW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (mag[i]) lz = XW'(SW - 1 - i);
    end
    shamt = '0;
    if (mag[SW]) begin
      norm  = {mag[SW:2], mag[1] | mag[0]};
      exp_n = XW'(e_big) + XW'(1);
    end else begin
      // Left shift stops at exponent 1 so tiny results come out subnormal.
      shamt = (lz < XW'(e_big)) ? lz : (XW'(e_big) - XW'(1));
      norm  = mag[SW-1:0] << shamt;
      exp_n = XW'(e_big) - shamt;
    end
    round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
    rounded  = {1'b0, norm[SW-1:3]} + (M+2)'(round_up);
    if (rounded[M+1]) begin
      exp_f  = exp_n + XW'(1);
      mant_f = rounded[M:1];
    end else begin
      exp_f  = rounded[M] ? exp_n : '0;
      mant_f = rounded[M-1:0];
    end
  end

  logic nan_a, nan_b, inf_a, inf_b;

  assign nan_a = is_nan(64'(a), BUS_WIDTH);
  assign nan_b = is_nan(64'(b), BUS_WIDTH);
  assign inf_a = is_inf(64'(a), BUS_WIDTH);
  assign inf_b = is_inf(64'(b), BUS_WIDTH);

  always_comb begin
    if (nan_a | nan_b | (inf_a & inf_b & eff_sub)) begin
      result = BUS_WIDTH'(nan_of(BUS_WIDTH));
    end else if (inf_a) begin
      result = a;
    end else if (inf_b) begin
      result = b;
    end else if (mag == '0) begin
      // Exact cancellation gives +0; only -0 + -0 keeps the sign.
      result = {sa & ~eff_sub, {(BUS_WIDTH-1){1'b0}}};
    end else if (exp_f >= EXP_MAX) begin
      result = BUS_WIDTH'(inf_of(BUS_WIDTH, sign_big));
    end else begin
      result = {sign_big, exp_f[E-1:0], mant_f};
    end
  end

endmodule

// File: rtl/fp_addsub_issue.sv
// Two-stage FADD/FSUB issue/retire shell around FPAdder (S1 operands, S2 result toward writeback).
// Define FP_ADD_EXC_FLAGS_EN to compute {invalid, overflow}; otherwise out_flags is constant zero.
module fp_addsub_issue
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sub,
  input  logic [BUS_WIDTH-1:0] in_a,
  input  logic [BUS_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [1:0]           out_flags
);

  logic                 s1_valid_reg;
  logic [BUS_WIDTH-1:0] s1_a_reg, s1_b_reg;
  logic [TAG_WIDTH-1:0] s1_tag_reg;

  logic                 s2_valid_reg;
  logic [BUS_WIDTH-1:0] s2_result_reg;
  logic [TAG_WIDTH-1:0] s2_tag_reg;
  logic [1:0]           s2_flags_reg;

  logic                 s2_adv, s1_adv, accept;
  logic [BUS_WIDTH-1:0] sum_next;
  logic [1:0]           flags_next;

  assign s2_adv   = ~s2_valid_reg | out_ready;
  assign s1_adv   = s2_adv;
  assign in_ready = ~flush & (~s1_valid_reg | s1_adv);
  assign accept   = in_valid & in_ready;

  FPAdder #(.BUS_WIDTH(BUS_WIDTH)) u_adder (
    .a      (s1_a_reg),
    .b      (s1_b_reg),
    .result (sum_next)
  );

`ifdef FP_ADD_EXC_FLAGS_EN
  always_comb begin
    flags_next                = 2'b00;
    flags_next[FLAG_INVALID]  = is_nan(64'(sum_next), BUS_WIDTH);
    flags_next[FLAG_OVERFLOW] = is_inf(64'(sum_next), BUS_WIDTH)
                              & ~is_inf(64'(s1_a_reg), BUS_WIDTH)
                              & ~is_inf(64'(s1_b_reg), BUS_WIDTH);
  end
`else
  assign flags_next = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_tag_reg    <= '0;
      s2_valid_reg  <= 1'b0;
      s2_result_reg <= '0;
      s2_tag_reg    <= '0;
      s2_flags_reg  <= 2'b00;
    end else if (flush) begin
      // Data registers keep their contents; only the valids are dropped.
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_result_reg <= sum_next;
          s2_tag_reg    <= s1_tag_reg;
          s2_flags_reg  <= flags_next;
        end
      end
      if (~s1_valid_reg | s1_adv) begin
        s1_valid_reg <= accept;
        if (accept) begin
          // FSUB only flips B's sign bit, so NaN payloads pass through untouched.
          s1_a_reg   <= in_a;
          s1_b_reg   <= {in_b[BUS_WIDTH-1] ^ in_sub, in_b[BUS_WIDTH-2:0]};
          s1_tag_reg <= in_tag;
        end
      end
    end
  end

  assign out_valid  = s2_valid_reg;
  assign out_result = s2_result_reg;
  assign out_tag    = s2_tag_reg;
  assign out_flags  = s2_flags_reg;

endmodule

// File: tb/tb_fp_addsub_issue.sv
// Scoreboard bench for fp_addsub_issue (BUS_WIDTH=64): directed cases, backpressure,
// throughput, flush and mid-stream reset; expected sums come from real arithmetic.
module tb_fp_addsub_issue;

  localparam int BW = 64;
  localparam int TW = 5;

`ifdef FP_ADD_EXC_FLAGS_EN
  localparam logic [1:0] INF_SUB_FLAGS = 2'b10;
`else
  localparam logic [1:0] INF_SUB_FLAGS = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sub = 1'b0;
  logic [BW-1:0] in_a = '0;
  logic [BW-1:0] in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_result;
  logic [TW-1:0] out_tag;
  logic [1:0]    out_flags;

  typedef struct packed {
    logic [BW-1:0] result;
    logic [TW-1:0] tag;
    logic [1:0]    flags;
  } exp_t;

  exp_t sb[$];
  int   deliv_cyc[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_addsub_issue #(.BUS_WIDTH(BW), .TAG_WIDTH(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sub     (in_sub),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_flags  (out_flags)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_add(input real ra, input real rb, input logic sub);
    real r;
    r = sub ? (ra - rb) : (ra + rb);
    return $realtobits(r);
  endfunction

  // Output monitor: every transfer is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_result", out_result, e.result);
        check("out_tag", out_tag, e.tag);
        check("out_flags", out_flags, e.flags);
        deliv_cyc.push_back(cyc);
        $display("xfer tag=%0d result=%h flags=%b", out_tag, out_result, out_flags);
      end
    end
  end

  task automatic send(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic sub,
                      input logic [TW-1:0] tag, input logic [BW-1:0] res, input logic [1:0] flg);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_tag   = tag;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{result: res, tag: tag, flags: flg});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", in_ready, 1'b1);
  endtask

  task automatic send_r(input real ra, input real rb, input logic sub, input logic [TW-1:0] tag);
    send($realtobits(ra), $realtobits(rb), sub, tag, model_add(ra, rb, sub), 2'b00);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] exp0;
    int            n0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 64'h0);
    check("rst_out_tag", out_tag, 5'd0);
    check("rst_out_flags", out_flags, 2'b00);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // 1. latency and add: 1.0 + 2.0
    out_ready = 1'b1;
    send(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 5'd3, 64'h4008000000000000, 2'b00);
    check("lat_edge1_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_edge2_valid", out_valid, 1'b1);
    check("lat_result", out_result, 64'h4008000000000000);
    check("lat_tag", out_tag, 5'd3);
    drain("drain_add");

    // 2. FSUB 1.0 - 1.0
    send(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, 5'd4, 64'h0, 2'b00);
    drain("drain_fsub");

    // 3. +inf + -inf
    send(64'h7FF0000000000000, 64'hFFF0000000000000, 1'b0, 5'd5, 64'h7FF8000000000000, INF_SUB_FLAGS);
    drain("drain_inf");

    // 4. backpressure: out_ready low for 5 cycles while streaming 4 ops
    out_ready = 1'b0;
    exp0 = model_add(1.5, 2.0, 1'b0);
    n0   = deliv_cyc.size();
    fork
      begin
        for (int k = 0; k < 4; k++) send_r(real'(k) + 1.5, real'(k) + 2.0, 1'b0, TW'(k));
      end
      begin
        repeat (3) @(posedge clk);
        repeat (2) begin
          @(negedge clk);
          check("bp_in_ready_low", in_ready, 1'b0);
          check("bp_out_valid", out_valid, 1'b1);
          check("bp_tag_stable", out_tag, 5'd0);
          check("bp_result_stable", out_result, exp0);
          @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_bp");
    check("bp_delivered", deliv_cyc.size() - n0, 4);

    // 5. throughput: 16 back-to-back ops
    deliv_cyc.delete();
    for (int k = 0; k < 16; k++) begin
      send_r(real'($urandom_range(0, 2000)) - 1000.0, real'($urandom_range(0, 2000)) - 1000.0,
             1'($urandom_range(0, 1)), TW'(k));
    end
    drain("drain_tput");
    check("tput_count", deliv_cyc.size(), 16);
    if (deliv_cyc.size() == 16) check("tput_span", deliv_cyc[15] - deliv_cyc[0], 15);

    // 6a. flush with two ops in flight
    out_ready = 1'b0;
    send_r(7.0, 1.0, 1'b0, 5'd20);
    send_r(9.0, 4.0, 1'b1, 5'd21);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb.delete();
    check("flush_out_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_r(10.0, 0.5, 1'b0, 5'd22);
    drain("drain_flush");

    // 6b. reset mid-stream
    out_ready = 1'b0;
    send_r(3.0, 4.0, 1'b0, 5'd23);
    send_r(5.0, 6.0, 1'b0, 5'd24);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_out_result", out_result, 64'h0);
    check("mrst_out_tag", out_tag, 5'd0);
    check("mrst_out_flags", out_flags, 2'b00);
    rst = 1'b0;
    sb.delete();
    #1;
    check("mrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_r(-8.0, 2.0, 1'b1, 5'd25);
    drain("drain_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
